// File: rtl/rf_writeback.sv
// rf_writeback -- write-side front end of the integer register file.
//
// Arbitrates ALU and LSU results onto the single register-file write port and
// keeps a per-register pending-write scoreboard so decode can stall on
// operands whose producing write has not reached the register file yet.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   alu_valid/ready/rd/data   ALU result handshake
//   lsu_valid/ready/rd/data   LSU result handshake
//   issue_valid/rd, issue_ready  decode issue of a register-writing instr
//   chk_ra/chk_rb, busy_a/busy_b  scoreboard lookups for source operands
//   reg_w_EN/rw/rw_data       registered register-file write port
//   sb_err                    sticky scoreboard underflow/overflow flag

// One pending-write counter. Increment and decrement in the same cycle
// cancel. Errors are reported, not absorbed into the count.
module rf_sb_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [1:0] cnt_o,
    output logic       err_o
);
    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        err_o = 1'b0;
        if (inc_i && !dec_i) begin
            if (cnt_q == 2'd3) err_o = 1'b1;
            else               cnt_d = cnt_q + 2'd1;
        end else if (dec_i && !inc_i) begin
            if (cnt_q == 2'd0) err_o = 1'b1;
            else               cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= 2'd0;
        else      cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

module rf_writeback #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            issue_ready,
    input  logic [4:0]      chk_ra,
    input  logic [4:0]      chk_rb,
    output logic            busy_a,
    output logic            busy_b,
    output logic            reg_w_EN,
    output logic [4:0]      rw,
    output logic [XLEN-1:0] rw_data,
    output logic            sb_err
);
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    // ---------------- arbitration ----------------
    logic [SW-1:0] starve_q, starve_d;
    logic          alu_grant, lsu_grant;

    // Grants look only at valids and the starvation count, never at data.
    // rst gating keeps both readies low while reset is held.
    assign alu_grant = rst && alu_valid && (!lsu_valid || (starve_q == SMAX));
    assign lsu_grant = rst && lsu_valid && !alu_grant;
    assign alu_ready = alu_grant;
    assign lsu_ready = lsu_grant;

    always_comb begin
        starve_d = '0;
        if (alu_valid && !alu_grant)
            starve_d = (starve_q == SMAX) ? starve_q : starve_q + SW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) starve_q <= '0;
        else      starve_q <= starve_d;
    end

    // ---------------- write port ----------------
    logic            wen_q, wen_d;
    logic [4:0]      rw_q, rw_d;
    logic [XLEN-1:0] data_q, data_d;

    // A beat to x0 is consumed but never reaches the register file; address
    // and data hold so the port does not toggle needlessly.
    always_comb begin
        wen_d  = 1'b0;
        rw_d   = rw_q;
        data_d = data_q;
        if (alu_grant) begin
            if (alu_rd != 5'd0) begin
                wen_d  = 1'b1;
                rw_d   = alu_rd;
                data_d = alu_data;
            end
        end else if (lsu_grant) begin
            if (lsu_rd != 5'd0) begin
                wen_d  = 1'b1;
                rw_d   = lsu_rd;
                data_d = lsu_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_q  <= 1'b0;
            rw_q   <= 5'd0;
            data_q <= '0;
        end else begin
            wen_q  <= wen_d;
            rw_q   <= rw_d;
            data_q <= data_d;
        end
    end

    assign reg_w_EN = wen_q;
    assign rw       = rw_q;
    assign rw_data  = data_q;

    // ---------------- scoreboard ----------------
    logic [31:0][1:0] cnt;
    logic [31:1]      err;
    logic             issue_fire;
    logic             err_q;

    assign cnt[0] = 2'd0;

    // The decrement keys off the registered write port, so the count drops
    // on the same edge the register file captures the data.
    genvar r;
    generate
        for (r = 1; r < 32; r++) begin : g_sb
            rf_sb_cnt u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc_i (issue_fire && (issue_rd == 5'(r))),
                .dec_i (wen_q && (rw_q == 5'(r))),
                .cnt_o (cnt[r]),
                .err_o (err[r])
            );
        end
    endgenerate

    assign issue_ready = (cnt[issue_rd] != 2'd3);
    assign issue_fire  = issue_valid && issue_ready && (issue_rd != 5'd0);
    assign busy_a      = (cnt[chk_ra] != 2'd0);
    assign busy_b      = (cnt[chk_rb] != 2'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      err_q <= 1'b0;
        else if (|err) err_q <= 1'b1;
    end

    assign sb_err = err_q;
endmodule

// File: doc/rf_writeback.md
# rf_writeback

Write-side front end of the integer register file. Accepts results from the ALU and LSU over valid/ready handshakes, arbitrates them onto the register file's single write port (`reg_w_EN`/`rw`/`rw_data`), and keeps a per-register pending-write scoreboard. Decode consults the scoreboard before reading `ra`/`rb`, so it never reads a stale operand.

## Interface
- XLEN, 32, data width; matches the register file data port
- STARVE_MAX, 3, consecutive lost arbitrations after which the ALU is granted
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- alu_valid / alu_ready  in / out  1  ALU result handshake
- alu_rd / alu_data  in  5 / XLEN  ALU destination and result
- lsu_valid / lsu_ready  in / out  1  LSU result handshake
- lsu_rd / lsu_data  in  5 / XLEN  LSU destination and result
- issue_valid  in  1  decode issues an instruction that writes `issue_rd`
- issue_rd  in  5  destination of the issuing instruction
- issue_ready  out  1  0 when `issue_rd`'s pending counter is saturated
- chk_ra / chk_rb  in  5  source registers decode is about to read
- busy_a / busy_b  out  1  a write to `chk_ra` / `chk_rb` is still outstanding
- reg_w_EN  out  1  register file write enable, registered
- rw  out  5  register file write address, registered
- rw_data  out  XLEN  register file write data, registered
- sb_err  out  1  sticky scoreboard underflow or overflow flag

## Operation
- **Scoreboard**
  - One 2-bit pending counter per register x1..x31; x0 is always 0 and never busy.
  - The counter increments on an issue handshake (`issue_valid && issue_ready`, `issue_rd != 0`).
  - The counter decrements at the clock edge where `reg_w_EN` is 1 for `rw`. This is the same edge on which the register file captures the data.
  - If increment and decrement hit the same register in one cycle, the counter is unchanged.
  - `issue_ready` = !(counter[issue_rd] == 3). It is combinational.
  - A decrement of a zero counter leaves it at 0 and sets `sb_err`. `sb_err` clears only on reset.
  - `busy_a` = (counter[chk_ra] != 0). `busy_b` is the same for `chk_rb`. Both are combinational.
- **Arbitration** (one accepted result per cycle)
  - Only LSU valid: `lsu_ready` = 1.
  - Only ALU valid: `alu_ready` = 1.
  - Both valid: LSU wins, unless the starvation counter equals STARVE_MAX, in which case the ALU wins.
  - Starvation counter: increments each cycle the ALU is valid and loses. It clears when the ALU is granted or `alu_valid` is 0. It saturates at STARVE_MAX.
  - Ready signals depend only on the valids and the starvation counter. There is no combinational path from data inputs to ready.
- **Write port**
  - An accepted beat with rd != 0 produces, next cycle, `reg_w_EN` = 1, `rw` = rd, `rw_data` = data.
  - An accepted beat with rd = 0 is consumed and produces `reg_w_EN` = 0.
  - With no accepted beat, `reg_w_EN` = 0. `rw` and `rw_data` hold their previous values.

## Timing
- Reset (rst = 0, asynchronous):
  - All counters, the starvation counter, `reg_w_EN`, `rw`, `rw_data` and `sb_err` go to 0.
  - `alu_ready` and `lsu_ready` are 0 while reset is asserted. `issue_ready` is 1 once the counters are 0.
- Reset asserted mid-operation: in-flight beats and pending counts are discarded. No write is issued after reset releases.
- Accept-to-write latency: a beat accepted at edge N appears on the write port after edge N and is written into the register file at edge N+1.
- The pending counter drops at edge N+1, so `busy_*` for that register falls in the same cycle the register file holds the new value. Decode sees no window of stale data.
- Back-to-back beats, one per cycle, sustain full throughput with no bubbles.
- Issue of rd and write-back of the same rd in the same cycle: the count is net unchanged, so `busy` stays high for the younger writer.

## Test plan
- Single ALU beat, rd = 5, data 0xDEADBEEF, preceded by an issue of rd 5 -> `busy` for x5 goes high. One cycle after the handshake, `reg_w_EN` = 1, `rw` = 5, `rw_data` = 0xDEADBEEF. `busy` drops after the following edge.
- ALU and LSU both valid continuously (STARVE_MAX = 3) -> grant sequence is LSU, LSU, LSU, ALU, repeating. No beat is lost or duplicated.
- Three issues of rd 7 without write-back -> `issue_ready` = 0 for rd 7 and 1 for rd 8. One write-back of x7 -> `issue_ready` returns to 1 and `busy` for x7 stays 1.
- Beat with rd = 0, data 0x1234 -> handshake completes, `reg_w_EN` stays 0, `busy` for x0 stays 0.
- Write-back of x9 with its counter at 0 -> `sb_err` = 1 and stays 1 until reset.
- rst pulsed low while two writes are pending -> all outputs are 0 immediately, `busy` is 0 for every register, and no `reg_w_EN` pulse appears after release.
